cram_responder: RTL
===================

// Module: cram_responder
// PURPOSE
//  Synthesizable Cellular RAM emulator: the memory-side responder to the RAM master's async SRAM pins
//  (address, DQ, nOE, nWE, nUB, nLB). Backs a block-RAM array so display/capture/MCS paths can run
//  on boards without the external RAM, and serves as the memory model in system benches.
//  All pins are sampled on CLK, the same clock that drives the master. No internal tristates:
//  DQ is split into DQ_I, DQ_O and a per-byte DQ_OE; the top level resolves the bus.
// PARAMETERS
//  AW      10  word-address bits implemented; MEMADDR[AW:1] used, upper bits ignored (aliasing)
//  RD_LAT  2   cycles from a stable read condition until DQ_O is valid; legal range 1..3
// PORTS
//  CLK      in   1   clock
//  RST      in   1   reset, synchronous, active-high
//  MEMADDR  in   23  word address [23:1]
//  DQ_I     in   16  bus value driven by the master
//  DQ_O     out  16  read data toward the bus
//  DQ_OE    out  2   byte drive enables: [1]=DQ[15:8], [0]=DQ[7:0]
//  MEMnOE   in   1   output enable, active-low
//  MEMnWE   in   1   write enable, active-low
//  MEMnUB   in   1   upper-byte select, active-low
//  MEMnLB   in   1   lower-byte select, active-low
//  RD_VALID out  1   DQ_O holds array data for the current address
//  WR_CNT   out  16  committed-write counter, wraps at 16'hFFFF
//  ERR      out  1   sticky: nOE and nWE were both low in the same cycle
// BEHAVIOUR
//  Reset: state=IDLE; DQ_O=0; DQ_OE=0; RD_VALID=0; WR_CNT=0; ERR=0. Array contents are not reset.
//  Registers: MEMnWE_q (previous cycle), addr_q (previous address), lat_cnt (2 bits).
//  States:
//   IDLE:
//    nWE=0 -> WRACT.
//    nOE=0 & nWE=1 -> RDWAIT; load lat_cnt=RD_LAT-1.
//   RDWAIT:
//    nOE=1 -> IDLE.
//    nWE=0 -> WRACT.
//    MEMADDR!=addr_q -> reload lat_cnt.
//    lat_cnt==0 -> RDVALID; else decrement lat_cnt.
//   RDVALID:
//    Array read continuously; a registered read is acceptable.
//    DQ_O = mem[MEMADDR], updated within RD_LAT cycles when the address changes.
//    An address change clears RD_VALID and returns to RDWAIT with lat_cnt reloaded.
//    nOE=1 -> IDLE; nWE=0 -> WRACT.
//   WRACT:
//    Each cycle with nWE=0, capture wa=MEMADDR[AW:1], wd=DQ_I, wbe=~{nUB,nLB}.
//    Commit on the nWE 0->1 edge (nWE=1 & MEMnWE_q=0), using values captured in the last low cycle.
//    mem[wa] hi byte <= wd[15:8] if wbe[1]; lo byte <= wd[7:0] if wbe[0].
//    Every commit increments WR_CNT, including wbe==0.
//    After the commit, go to RDWAIT if nOE=0, else IDLE.
//    An address change while nWE=0 does not commit; the last sampled address wins.
//  DQ_OE = {~nUB,~nLB} & {2{state==RDVALID || state==RDWAIT}} & {2{nWE}}.
//   A deselected byte is not driven and its DQ_O byte reads 8'h00.
//  DQ_O before RD_VALID is 16'h0000; the master must sample only after RD_LAT.
//  nOE=0 & nWE=0 in the same cycle: write takes priority, DQ_OE=0, ERR<=1 (cleared only by RST).
//  Read-after-write to the same address with no idle cycle returns the new data (write-first).
//  RST mid-write: the pending capture is discarded, no commit, WR_CNT=0.
//  RST mid-read: DQ_OE drops in the next cycle.
//  Master compatibility: a 32-bit access is 2 word cycles (addr bit1 = 0 then 1). With RD_LAT<=2,
//   the low word is valid before the master's first sample 3 cycles after address setup.
// TESTING
//  1. Write 16'hA55A at word 5, UB=LB=0, nWE low 3 cycles -> WR_CNT=1; read with nOE=0 -> RD_VALID
//     after RD_LAT=2 cycles, DQ_O=16'hA55A, DQ_OE=2'b11.
//  2. Byte write: mem[7]=16'h1234, then write 16'hFFFF with nUB=1 -> read 16'h12FF;
//     read with nLB=1 -> DQ_OE=2'b10, DQ_O=16'h1200.
//  3. Address change during RDVALID, 5 -> 6 -> RD_VALID=0 for exactly RD_LAT cycles,
//     then DQ_O=mem[6].
//  4. nOE=0 & nWE=0 together with DQ_I=16'hBEEF -> ERR=1, DQ_OE=0, write commits;
//     ERR stays 1 until RST.
//  5. RST asserted while nWE=0 at addr 9 (mem[9]=16'h0F0F) -> after RST, mem[9]=16'h0F0F, WR_CNT=0.
//  6. Alias: AW=10; write addr 23'h000403, then read addr 23'h000003 -> same data; 32-bit
//     write-then-read sequence driven in the master's pin order -> both halves match.

Source files
------------

// File: rtl/cram_responder.sv
// Cellular RAM responder: answers the master's async SRAM pins from an internal array.
// All pins are sampled on CLK; DQ is split into DQ_I / DQ_O / DQ_OE for top-level resolution.
module cram_responder #(
  parameter int unsigned AW     = 10,
  parameter int unsigned RD_LAT = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [23:1] MEMADDR,
  input  logic [15:0] DQ_I,
  output logic [15:0] DQ_O,
  output logic [1:0]  DQ_OE,
  input  logic        MEMnOE,
  input  logic        MEMnWE,
  input  logic        MEMnUB,
  input  logic        MEMnLB,
  output logic        RD_VALID,
  output logic [15:0] WR_CNT,
  output logic        ERR
);

  typedef enum logic [1:0] {StIdle, StRdWait, StRdValid, StWrAct} state_e;

  localparam logic [1:0] LatInit = 2'(RD_LAT - 1);

  state_e        state_q, state_d;
  logic [1:0]    lat_q, lat_d;
  logic [AW-1:0] addr_q;
  logic          MEMnWE_q;
  logic [AW-1:0] wa_q;
  logic [15:0]   wd_q;
  logic [1:0]    wbe_q;
  logic [15:0]   wr_cnt_q;
  logic          err_q;

  logic [15:0]   mem [2**AW];

  logic [AW-1:0] addr;
  logic          addr_chg;
  logic          commit;
  logic [1:0]    lane;
  logic [15:0]   rd_data;
  logic          addr_unused;

  // Upper address bits alias onto the implemented word range.
  assign addr        = MEMADDR[AW:1];
  assign addr_unused = ^MEMADDR;
  assign addr_chg    = (addr != addr_q);
  assign lane        = ~{MEMnUB, MEMnLB};
  assign rd_data     = mem[addr];
  // Commit on the rising edge of nWE, using the capture from the last low cycle.
  assign commit      = (state_q == StWrAct) && MEMnWE && !MEMnWE_q;

  assign WR_CNT = wr_cnt_q;
  assign ERR    = err_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      lat_q    <= '0;
      addr_q   <= '0;
      MEMnWE_q <= 1'b1;
      wa_q     <= '0;
      wd_q     <= '0;
      wbe_q    <= '0;
      wr_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      addr_q   <= addr;
      MEMnWE_q <= MEMnWE;
      if (!MEMnWE) begin
        wa_q  <= addr;
        wd_q  <= DQ_I;
        wbe_q <= lane;
      end
      if (commit) wr_cnt_q <= wr_cnt_q + 16'd1;
      if (!MEMnOE && !MEMnWE) err_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (commit && !RST) begin
      if (wbe_q[1]) mem[wa_q][15:8] <= wd_q[15:8];
      if (wbe_q[0]) mem[wa_q][7:0]  <= wd_q[7:0];
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    unique case (state_q)
      StIdle: begin
        if (!MEMnWE) begin
          state_d = StWrAct;
        end else if (!MEMnOE) begin
          state_d = StRdWait;
          lat_d   = LatInit;
        end
      end
      StRdWait: begin
        if (!MEMnWE)             state_d = StWrAct;
        else if (MEMnOE)         state_d = StIdle;
        else if (addr_chg)       lat_d   = LatInit;
        else if (lat_q == 2'd0)  state_d = StRdValid;
        else                     lat_d   = lat_q - 2'd1;
      end
      StRdValid: begin
        if (!MEMnWE) begin
          state_d = StWrAct;
        end else if (MEMnOE) begin
          state_d = StIdle;
        end else if (addr_chg) begin
          state_d = StRdWait;
          lat_d   = LatInit;
        end
      end
      StWrAct: begin
        if (MEMnWE) begin
          state_d = MEMnOE ? StIdle : StRdWait;
          lat_d   = LatInit;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    DQ_OE    = 2'b00;
    DQ_O     = 16'h0000;
    RD_VALID = 1'b0;
    if ((state_q == StRdWait || state_q == StRdValid) && MEMnWE) DQ_OE = lane;
    if (state_q == StRdValid) begin
      RD_VALID = 1'b1;
      DQ_O     = rd_data & {{8{lane[1]}}, {8{lane[0]}}};
    end
  end

endmodule
